vga_sync_transmitter: RTL

//  Generates VGA raster timing: free-running column/row counters, HSync/VSync

---
 rtl/vga_sync_transmitter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vga_sync_transmitter.sv
// VGA raster timing generator and pin-side video blanking stage.
// Latency: counts registered; syncs and video reach the pins PIPE_DELAY+1 cycles after their counts.
// Backpressure: none; the raster free-runs while i_Enable=1, and i_Enable=0 holds it at (0,0) and idle.
//
// Ports:
//   i_Clk, i_Rst (async, active high), i_Enable
//   o_Col_Count / o_Row_Count : registered raster position handed to render logic
//   o_Active, o_Frame_Start   : visible-area flag and (0,0) strobe, aligned with the counts
//   i_*_Video                 : render colour, arriving PIPE_DELAY cycles after its counts
//   o_HSync / o_VSync         : active-low syncs to the pins
//   o_*_Video                 : colour to the pins, forced to 0 outside the visible area
module vga_sync_transmitter #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int VIDEO_WIDTH   = 4,
    parameter int PIPE_DELAY    = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Enable,
    output logic [9:0]             o_Col_Count,
    output logic [9:0]             o_Row_Count,
    output logic                   o_Active,
    output logic                   o_Frame_Start,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

    // Phase boundaries on each axis: first column/row of each phase.
    localparam logic [9:0] H_FRONT_START = 10'(ACTIVE_COLS);
    localparam logic [9:0] H_SYNC_START  = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] H_BACK_START  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [9:0] H_LAST        = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] V_FRONT_START = 10'(ACTIVE_ROWS);
    localparam logic [9:0] V_SYNC_START  = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] V_BACK_START  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [9:0] V_LAST        = 10'(TOTAL_ROWS - 1);

    // A sync pulse that runs into or past the end of the line/frame would never
    // see its back porch, so refuse such a configuration outright.
    if ((ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH >= TOTAL_COLS) ||
        (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH >= TOTAL_ROWS) ||
        (PIPE_DELAY < 1)) begin : g_param_check
        $error("vga_sync_transmitter: active+front+sync must be < total on both axes, PIPE_DELAY >= 1");
    end

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_FRONT,
        ST_SYNC,
        ST_BACK
    } phase_e;

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    phase_e     h_state_q, v_state_q;
    logic       line_end;

    logic [PIPE_DELAY-1:0]  hs_pipe_q, vs_pipe_q, act_pipe_q;
    logic                   hs_in, vs_in, act_in;
    logic                   hsync_q, vsync_q;
    logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;

    // Phase transitions happen when the upcoming count lands on a boundary,
    // so the registered state always describes the registered count.
    function automatic phase_e next_phase(
        input logic [9:0] cnt,
        input logic [9:0] front_start,
        input logic [9:0] sync_start,
        input logic [9:0] back_start,
        input phase_e     cur
    );
        phase_e nxt;
        nxt = cur;
        if (cnt == 10'd0)             nxt = ST_ACTIVE;
        else if (cnt == front_start)  nxt = ST_FRONT;
        else if (cnt == sync_start)   nxt = ST_SYNC;
        else if (cnt == back_start)   nxt = ST_BACK;
        return nxt;
    endfunction

    assign line_end = (col_q == H_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (!i_Enable) begin
            col_d = 10'd0;
            row_d = 10'd0;
        end else if (line_end) begin
            col_d = 10'd0;
            row_d = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
        end else begin
            col_d = col_q + 10'd1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            col_q     <= 10'd0;
            row_q     <= 10'd0;
            h_state_q <= ST_ACTIVE;
            v_state_q <= ST_ACTIVE;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (!i_Enable) begin
                h_state_q <= ST_ACTIVE;
                v_state_q <= ST_ACTIVE;
            end else begin
                h_state_q <= next_phase(col_d, H_FRONT_START, H_SYNC_START, H_BACK_START, h_state_q);
                if (line_end) begin
                    v_state_q <= next_phase(row_d, V_FRONT_START, V_SYNC_START, V_BACK_START, v_state_q);
                end
            end
        end
    end

    // While disabled the counts may still show the pre-disable position for a
    // cycle, so idle values are fed into the delay line rather than decoded state.
    assign hs_in  = i_Enable ? (h_state_q != ST_SYNC) : 1'b1;
    assign vs_in  = i_Enable ? (v_state_q != ST_SYNC) : 1'b1;
    assign act_in = i_Enable && (h_state_q == ST_ACTIVE) && (v_state_q == ST_ACTIVE);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            act_pipe_q <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            red_q      <= '0;
            grn_q      <= '0;
            blu_q      <= '0;
        end else begin
            hs_pipe_q[0]  <= hs_in;
            vs_pipe_q[0]  <= vs_in;
            act_pipe_q[0] <= act_in;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe_q[i]  <= hs_pipe_q[i-1];
                vs_pipe_q[i]  <= vs_pipe_q[i-1];
                act_pipe_q[i] <= act_pipe_q[i-1];
            end
            // Last stage lines up with the render colour for the same pixel.
            hsync_q <= hs_pipe_q[PIPE_DELAY-1];
            vsync_q <= vs_pipe_q[PIPE_DELAY-1];
            red_q   <= act_pipe_q[PIPE_DELAY-1] ? i_Red_Video : '0;
            grn_q   <= act_pipe_q[PIPE_DELAY-1] ? i_Grn_Video : '0;
            blu_q   <= act_pipe_q[PIPE_DELAY-1] ? i_Blu_Video : '0;
        end
    end

    assign o_Col_Count = col_q;
    assign o_Row_Count = row_q;
    // Gated so reset and disable read as idle even though the counts sit at (0,0).
    assign o_Active      = i_Enable && !i_Rst && (col_q < H_FRONT_START) && (row_q < V_FRONT_START);
    assign o_Frame_Start = i_Enable && !i_Rst && (col_q == 10'd0) && (row_q == 10'd0);
    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_Red_Video   = red_q;
    assign o_Grn_Video   = grn_q;
    assign o_Blu_Video   = blu_q;

endmodule
